aes_bram_arbiter: RTL
=====================

# aes_bram_arbiter

Round-robin arbiter that shares the single BRAM access port (start/complete handshake, 32-bit address and data) among `NUM_REQ` requesters, e.g. the AES read/write sequencers of several AES datapath instances. It serialises accesses, applies fair rotation, returns read data and completion pulses to the winning requester, and aborts any access the BRAM side never completes. It sits between the AES top-level sequencers and the BRAM/AXI bridge.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters. Must be ≥2. `IDW = $clog2(NUM_REQ)`.
- `TIMEOUT_CYCLES`, 256: maximum number of WAIT cycles before an access is aborted. Must be ≥2.

Ports (requester `i` uses slice `i`):
- `aes_clk` in 1: the single clock. All logic is rising-edge.
- `aes_rst_n` in 1: asynchronous, active-low reset.
- `req_start_read` in NUM_REQ: level read request. Held until `req_complete[i]`.
- `req_start_write` in NUM_REQ: level write request. Held until `req_complete[i]`.
- `req_addr` in 32*NUM_REQ: byte address. Stable while the request is held.
- `req_write_data` in 32*NUM_REQ: write data. Stable while the request is held.
- `req_complete` out NUM_REQ: one-cycle completion pulse to the granted requester.
- `req_error` out NUM_REQ: one-cycle pulse, coincident with `req_complete`, on timeout or protocol error.
- `req_read_data` out 32: data from the last successful read. Held until the next successful read.
- `bram_start_read` out 1: level read strobe to the BRAM bridge.
- `bram_start_write` out 1: level write strobe to the BRAM bridge.
- `bram_addr` out 32: address to the BRAM bridge.
- `bram_write_data` out 32: write data to the BRAM bridge.
- `bram_read_data` in 32: read data, valid when `bram_complete` is high.
- `bram_complete` in 1: one-cycle completion pulse from the BRAM bridge.
- `arb_busy` out 1: high whenever state ≠ IDLE.
- `arb_grant_id` out IDW: index of the current or last granted requester.
- `arb_grant_count` out 32: count of grants. Wraps modulo 2^32.
- `arb_timeout_count` out 16: count of timeouts. Saturates at 16'hFFFF.

## Operation
- Reset values: every output is 0, state is IDLE, the rotation pointer `last` is NUM_REQ-1 (so requester 0 wins first), and the WAIT counter is 0.
- The state machine has three states: IDLE, WAIT and DONE.
- A requester is pending when `req_start_read[i] | req_start_write[i]`.
- IDLE, with any request pending:
  - Grant the first pending index searching `last+1, last+2, …` modulo NUM_REQ.
  - Set `last` and `arb_grant_id` to the winner and increment `arb_grant_count`.
  - Register `bram_addr` and `bram_write_data` from the winner's slices.
  - Normal request (exactly one of read/write set): assert the matching `bram_start_*`, go to WAIT, clear the WAIT counter.
  - Protocol error (read and write both set): no BRAM strobe; go to DONE with the error flag set.
- IDLE, with no request pending: stay in IDLE; outputs hold.
- WAIT:
  - If `bram_complete`: drop `bram_start_*`. For a read, capture `bram_read_data` into `req_read_data`. Go to DONE with no error.
  - Else if the WAIT counter equals TIMEOUT_CYCLES-1: drop `bram_start_*`, increment `arb_timeout_count` (saturating), and go to DONE with the error flag set.
  - Otherwise increment the WAIT counter.
- DONE:
  - `req_complete[grant]` is high for exactly this cycle.
  - `req_error[grant]` is high in this cycle if the error flag is set.
  - Next state is IDLE.
- A requester drops its start on the edge that samples its `req_complete`. Its request is therefore not seen in the following IDLE cycle.
- `bram_complete` in IDLE or DONE is ignored. This covers a late completion after a timeout.
- Request changes in WAIT or DONE have no effect. Address and data are registered at grant.
- Changes on non-granted requesters never disturb the granted transfer.
- If the requester drops its start during WAIT, the transfer still completes and the pulse is still issued.
- Asserting `aes_rst_n` mid-transfer immediately clears all outputs and returns to IDLE. The in-flight access is lost and no completion pulse is generated.

## Timing
- Request high in cycle 0 (IDLE) → `bram_start_*`, `bram_addr` and `arb_busy` high from cycle 1.
- `bram_complete` in cycle c → `bram_start_*` low, `req_read_data` updated, and `req_complete` high in cycle c+1.
- Next IDLE is cycle c+2; the next grant's strobe rises in cycle c+3.
- Best case: `bram_complete` in cycle 1, `req_complete` in cycle 2, back-to-back strobe period 3 cycles.
- Timeout with no `bram_complete`:
  - The strobe is high in cycles 1..TIMEOUT_CYCLES.
  - `req_complete` and `req_error` pulse in cycle TIMEOUT_CYCLES+1.
- Protocol error: request in cycle 0 → `req_complete` and `req_error` in cycle 1, with no strobe.
- `arb_grant_count` and `arb_grant_id` update on the edge ending the grant cycle.

## Test plan
- Reset, then requester 0 reads 0x40 with `bram_complete` in cycle 3 carrying 0xDEADBEEF → strobe in cycles 1–3, `req_complete[0]` in cycle 4, `req_read_data` = 0xDEADBEEF, `arb_grant_count` = 1.
- NUM_REQ=2, both requesters hold writes and the bridge always completes in 1 cycle → grants alternate 0,1,0,1, and each write's `bram_addr`/`bram_write_data` match its own slices.
- TIMEOUT_CYCLES=8, requester 1 reads and `bram_complete` never comes → strobe high 8 cycles, `req_complete[1]` and `req_error[1]` in cycle 9, `arb_timeout_count` = 1. A stray `bram_complete` in cycle 11 is ignored and `req_read_data` is unchanged.
- Requester 0 asserts read and write together → `req_complete[0]` and `req_error[0]` in cycle 1, BRAM strobes never assert.
- Reset asserted during WAIT → all outputs 0 immediately. After release, requester 0 wins first even if requester 1 was granted before reset.
- Force 0xFFFF timeouts, then one more → `arb_timeout_count` stays 16'hFFFF. Separately, preload/drive `arb_grant_count` to wrap 0xFFFFFFFF → 0.

Source files
------------

// File: rtl/aes_bram_arbiter.sv
// Round-robin arbiter sharing one BRAM start/complete port among NUM_REQ requesters.
// Serialises accesses, returns completion/error pulses and aborts accesses that never complete.
module aes_bram_arbiter #(
   parameter int          NUM_REQ           = 2,
   parameter int          TIMEOUT_CYCLES    = 256,
   parameter logic [31:0] GRANT_COUNT_RST   = 32'h0000_0000,
   parameter logic [15:0] TIMEOUT_COUNT_RST = 16'h0000,
   localparam int         IDW               = $clog2(NUM_REQ)
) (
   input  logic                  aes_clk,
   input  logic                  aes_rst_n,
   input  logic [NUM_REQ-1:0]    req_start_read,
   input  logic [NUM_REQ-1:0]    req_start_write,
   input  logic [32*NUM_REQ-1:0] req_addr,
   input  logic [32*NUM_REQ-1:0] req_write_data,
   output logic [NUM_REQ-1:0]    req_complete,
   output logic [NUM_REQ-1:0]    req_error,
   output logic [31:0]           req_read_data,
   output logic                  bram_start_read,
   output logic                  bram_start_write,
   output logic [31:0]           bram_addr,
   output logic [31:0]           bram_write_data,
   input  logic [31:0]           bram_read_data,
   input  logic                  bram_complete,
   output logic                  arb_busy,
   output logic [IDW-1:0]        arb_grant_id,
   output logic [31:0]           arb_grant_count,
   output logic [15:0]           arb_timeout_count
);
   localparam int                 CW        = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]      WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [IDW-1:0]     LAST_RST  = IDW'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [IDW-1:0]       r_last;
   logic [IDW-1:0]       r_grant_id;
   logic [31:0]          r_grant_cnt;
   logic [15:0]          r_tout_cnt;
   logic [CW-1:0]        r_wait_cnt;
   logic                 r_bram_rd;
   logic                 r_bram_wr;
   logic [31:0]          r_bram_addr;
   logic [31:0]          r_bram_wdata;
   logic [31:0]          r_rdata;
   logic [NUM_REQ-1:0]   r_complete;
   logic [NUM_REQ-1:0]   r_error;
   logic                 r_busy;

   logic [NUM_REQ-1:0]   w_pending;
   logic                 w_found;
   logic                 w_take;
   logic [IDW-1:0]       w_cand;
   logic [IDW-1:0]       w_winner;
   logic                 w_win_rd;
   logic                 w_win_wr;
   logic [31:0]          w_win_addr;
   logic [31:0]          w_win_wdata;
   logic [NUM_REQ-1:0]   w_win_oh;
   logic [NUM_REQ-1:0]   w_grant_oh;

   assign w_pending  = req_start_read | req_start_write;
   assign w_win_oh   = ONE_HOT0 << w_winner;
   assign w_grant_oh = ONE_HOT0 << r_grant_id;

   // Rotating search starting just after the last winner; first pending index wins.
   always_comb begin
      w_found     = 1'b0;
      w_take      = 1'b0;
      w_cand      = '0;
      w_winner    = r_last;
      w_win_rd    = 1'b0;
      w_win_wr    = 1'b0;
      w_win_addr  = 32'h0000_0000;
      w_win_wdata = 32'h0000_0000;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand      = IDW'((int'(r_last) + k) % NUM_REQ);
         w_take      = !w_found && w_pending[w_cand];
         w_winner    = w_take ? w_cand : w_winner;
         w_win_rd    = w_take ? req_start_read[w_cand] : w_win_rd;
         w_win_wr    = w_take ? req_start_write[w_cand] : w_win_wr;
         w_win_addr  = w_take ? req_addr[32*int'(w_cand) +: 32] : w_win_addr;
         w_win_wdata = w_take ? req_write_data[32*int'(w_cand) +: 32] : w_win_wdata;
         w_found     = w_found | w_take;
      end
   end

   // Arbitration state machine with all outputs registered.
   always_ff @(posedge aes_clk or negedge aes_rst_n) begin
      if (!aes_rst_n) begin
         r_state      <= ST_IDLE;
         r_last       <= LAST_RST;
         r_grant_id   <= '0;
         r_grant_cnt  <= GRANT_COUNT_RST;
         r_tout_cnt   <= TIMEOUT_COUNT_RST;
         r_wait_cnt   <= '0;
         r_bram_rd    <= 1'b0;
         r_bram_wr    <= 1'b0;
         r_bram_addr  <= 32'h0000_0000;
         r_bram_wdata <= 32'h0000_0000;
         r_rdata      <= 32'h0000_0000;
         r_complete   <= '0;
         r_error      <= '0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_last       <= w_winner;
                  r_grant_id   <= w_winner;
                  r_grant_cnt  <= r_grant_cnt + 32'd1;
                  r_bram_addr  <= w_win_addr;
                  r_bram_wdata <= w_win_wdata;
                  r_busy       <= 1'b1;
                  // Read and write together is a protocol error: finish at once, no strobe.
                  if (w_win_rd && w_win_wr) begin
                     r_complete <= w_win_oh;
                     r_error    <= w_win_oh;
                     r_state    <= ST_DONE;
                  end else begin
                     r_bram_rd  <= w_win_rd;
                     r_bram_wr  <= w_win_wr;
                     r_wait_cnt <= '0;
                     r_state    <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (bram_complete) begin
                  if (r_bram_rd) begin
                     r_rdata <= bram_read_data;
                  end
                  r_bram_rd  <= 1'b0;
                  r_bram_wr  <= 1'b0;
                  r_complete <= w_grant_oh;
                  r_error    <= '0;
                  r_state    <= ST_DONE;
               end else if (r_wait_cnt == WAIT_LAST) begin
                  r_bram_rd  <= 1'b0;
                  r_bram_wr  <= 1'b0;
                  r_tout_cnt <= (r_tout_cnt == 16'hFFFF) ? r_tout_cnt : r_tout_cnt + 16'd1;
                  r_complete <= w_grant_oh;
                  r_error    <= w_grant_oh;
                  r_state    <= ST_DONE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            ST_DONE: begin
               r_complete <= '0;
               r_error    <= '0;
               r_busy     <= 1'b0;
               r_state    <= ST_IDLE;
            end
            default: begin
               r_bram_rd  <= 1'b0;
               r_bram_wr  <= 1'b0;
               r_complete <= '0;
               r_error    <= '0;
               r_busy     <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_complete      = r_complete;
   assign req_error         = r_error;
   assign req_read_data     = r_rdata;
   assign bram_start_read   = r_bram_rd;
   assign bram_start_write  = r_bram_wr;
   assign bram_addr         = r_bram_addr;
   assign bram_write_data   = r_bram_wdata;
   assign arb_busy          = r_busy;
   assign arb_grant_id      = r_grant_id;
   assign arb_grant_count   = r_grant_cnt;
   assign arb_timeout_count = r_tout_cnt;

endmodule
